// File: rtl/soc_addr_map_pkg.sv
// Shared types and encodings for the programmable SoC address map.
// The default rule table below is the reset image of the rule registers.
package soc_addr_map_pkg;

  localparam int NUM_RULES_DEF = 14;
  localparam int ADDR_W = 64;
  localparam int IDX_W = 32;

  typedef enum logic [1:0] {
    FIELD_START = 2'd0,
    FIELD_END   = 2'd1,
    FIELD_IDX   = 2'd2,
    FIELD_EN    = 2'd3
  } cfg_field_e;

  // Control register bank, addressed with rule_sel == NumRules
  localparam logic [1:0] CTRL_FIELD     = 2'd0;
  localparam logic [1:0] LOG_ADDR_FIELD = 2'd1;
  localparam logic [1:0] LOG_CNT_FIELD  = 2'd2;
  localparam logic [1:0] LOG_FLAG_FIELD = 2'd3;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              en;
  } addr_map_rule_t;

  // The L2 mailbox (rule 7) sits below L2SPM (rule 5) so the two never overlap
  localparam addr_map_rule_t [NUM_RULES_DEF-1:0] SOC_DEFAULT_RULES = '{
    13: '{32'd13, 64'h0000_0000_8000_0000, 64'h0000_0000_C000_0000, 1'b1},
    12: '{32'd12, 64'h0000_0000_0300_8000, 64'h0000_0000_0300_9000, 1'b1},
    11: '{32'd11, 64'h0000_0000_0300_6000, 64'h0000_0000_0300_7000, 1'b1},
    10: '{32'd10, 64'h0000_0000_0300_5000, 64'h0000_0000_0300_6000, 1'b1},
    9:  '{32'd9,  64'h0000_0000_0300_3000, 64'h0000_0000_0300_4000, 1'b1},
    8:  '{32'd8,  64'h0000_0000_0300_2000, 64'h0000_0000_0300_3000, 1'b1},
    7:  '{32'd7,  64'h0000_0000_1C00_0000, 64'h0000_0000_1C00_0100, 1'b1},
    6:  '{32'd6,  64'h0000_0000_2000_0000, 64'h0000_0000_2000_1000, 1'b1},
    5:  '{32'd5,  64'h0000_0000_1C00_0100, 64'h0000_0000_1C08_0000, 1'b1},
    4:  '{32'd4,  64'h0000_0000_1000_0000, 64'h0000_0000_1100_0000, 1'b1},
    3:  '{32'd3,  64'h0000_0000_0C00_0000, 64'h0000_0000_1000_0000, 1'b1},
    2:  '{32'd2,  64'h0000_0000_0200_0000, 64'h0000_0000_020C_0000, 1'b1},
    1:  '{32'd1,  64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000, 1'b1},
    0:  '{32'd0,  64'h0000_0000_0000_0000, 64'h0000_0000_0000_1000, 1'b1}
  };

endpackage

// File: rtl/soc_addr_map_if.sv
// Decode stream and config port of the address map unit.
interface soc_addr_map_if #(
  parameter int NumRules  = 14,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = 32
) ();
  localparam int RW = $clog2(NumRules);

  logic                 dec_valid_i;
  logic                 dec_ready_o;
  logic [AddrWidth-1:0] dec_addr_i;
  logic                 dec_valid_o;
  logic                 dec_ready_i;
  logic [IdxWidth-1:0]  dec_idx_o;
  logic                 dec_hit_o;
  logic [RW-1:0]        dec_rule_o;
  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [RW+1:0]        cfg_addr_i;
  logic [63:0]          cfg_wdata_i;
  logic [63:0]          cfg_rdata_o;
  logic                 cfg_rvalid_o;

  modport slave (
    input  dec_valid_i, dec_addr_i, dec_ready_i, cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output dec_ready_o, dec_valid_o, dec_idx_o, dec_hit_o, dec_rule_o, cfg_rdata_o, cfg_rvalid_o
  );

  modport master (
    output dec_valid_i, dec_addr_i, dec_ready_i, cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  dec_ready_o, dec_valid_o, dec_idx_o, dec_hit_o, dec_rule_o, cfg_rdata_o, cfg_rvalid_o
  );
endinterface

// File: rtl/soc_addr_map_match.sv
// Combinational priority matcher: lowest-numbered enabled rule with start <= addr < end wins.
module soc_addr_map_match #(
  parameter int NumRules  = 14,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = 32,
  localparam int RW = $clog2(NumRules)
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] rule_start [NumRules],
  input  logic [AddrWidth-1:0] rule_end   [NumRules],
  input  logic [IdxWidth-1:0]  rule_idx   [NumRules],
  input  logic [NumRules-1:0]  rule_en,
  output logic                 hit,
  output logic [RW-1:0]        rule,
  output logic [IdxWidth-1:0]  idx
);

  logic [NumRules-1:0] match_vec;

  // An empty or inverted range (end <= start) can never satisfy both bounds
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_cmp
    assign match_vec[gi] = rule_en[gi] && (addr >= rule_start[gi]) && (addr < rule_end[gi]);
  end

  always_comb begin
    hit  = 1'b0;
    rule = '0;
    idx  = '0;
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (match_vec[r]) begin
        hit  = 1'b1;
        rule = RW'(r);
        idx  = rule_idx[r];
      end
    end
  end

endmodule

// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable address map with a one-stage valid/ready decode pipeline.
// Define ADDR_MAP_MISS_LOG_EN to add the miss counter / first-miss capture registers.
module soc_addr_map_unit
  import soc_addr_map_pkg::*;
#(
  parameter int NumRules  = 14,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = 32,
  parameter addr_map_rule_t [NumRules-1:0] RuleDefault = SOC_DEFAULT_RULES,
  parameter logic [IdxWidth-1:0] DefaultIdx = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  soc_addr_map_if.slave bus
);
  localparam int RW = $clog2(NumRules);

  logic [AddrWidth-1:0] rule_start [NumRules];
  logic [AddrWidth-1:0] rule_end   [NumRules];
  logic [IdxWidth-1:0]  rule_idx   [NumRules];
  logic [NumRules-1:0]  rule_en;

  logic          lock_reg, default_en_reg;
  logic [RW-1:0] rule_sel;
  logic [1:0]    field;
  logic          cfg_wr, sel_ctrl, sel_rule;

  assign {rule_sel, field} = bus.cfg_addr_i;
  assign cfg_wr   = bus.cfg_req_i && bus.cfg_we_i;
  assign sel_ctrl = ({1'b0, rule_sel} == (RW + 1)'(NumRules));
  assign sel_rule = (int'(rule_sel) < NumRules);

  for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
    logic [AddrWidth-1:0] start_reg, end_reg;
    logic [IdxWidth-1:0]  idx_reg;
    logic                 en_reg;
    logic                 wr_rule;

    assign wr_rule = cfg_wr && !lock_reg && (rule_sel == RW'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        start_reg <= RuleDefault[gi].start_addr[AddrWidth-1:0];
        end_reg   <= RuleDefault[gi].end_addr[AddrWidth-1:0];
        idx_reg   <= RuleDefault[gi].idx[IdxWidth-1:0];
        en_reg    <= 1'b1;
      end else if (wr_rule) begin
        case (cfg_field_e'(field))
          FIELD_START: start_reg <= bus.cfg_wdata_i[AddrWidth-1:0];
          FIELD_END:   end_reg   <= bus.cfg_wdata_i[AddrWidth-1:0];
          FIELD_IDX:   idx_reg   <= bus.cfg_wdata_i[IdxWidth-1:0];
          default:     en_reg    <= bus.cfg_wdata_i[0];
        endcase
      end
    end

    assign rule_start[gi] = start_reg;
    assign rule_end[gi]   = end_reg;
    assign rule_idx[gi]   = idx_reg;
    assign rule_en[gi]    = en_reg;
  end

  // Lock is write-1-set: once set, the whole control write is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_reg       <= 1'b0;
      default_en_reg <= 1'b0;
    end else if (cfg_wr && sel_ctrl && field == CTRL_FIELD && !lock_reg) begin
      lock_reg       <= bus.cfg_wdata_i[0];
      default_en_reg <= bus.cfg_wdata_i[1];
    end
  end

  logic                match_hit;
  logic [RW-1:0]       match_rule;
  logic [IdxWidth-1:0] match_idx;

  soc_addr_map_match #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_match (
    .addr       (bus.dec_addr_i),
    .rule_start (rule_start),
    .rule_end   (rule_end),
    .rule_idx   (rule_idx),
    .rule_en    (rule_en),
    .hit        (match_hit),
    .rule       (match_rule),
    .idx        (match_idx)
  );

  logic                dec_valid_reg, dec_hit_reg, dec_hit_next;
  logic [IdxWidth-1:0] dec_idx_reg, dec_idx_next;
  logic [RW-1:0]       dec_rule_reg;
  logic                dec_ready, dec_accept;

  assign dec_ready  = !dec_valid_reg || bus.dec_ready_i;
  assign dec_accept = bus.dec_valid_i && dec_ready;

  always_comb begin
    dec_hit_next = match_hit || default_en_reg;
    dec_idx_next = match_idx;
    if (!match_hit) dec_idx_next = default_en_reg ? DefaultIdx : '0;
  end

  // The table is read before any same-cycle config write lands, so decodes see the old value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_reg <= 1'b0;
      dec_idx_reg   <= '0;
      dec_hit_reg   <= 1'b0;
      dec_rule_reg  <= '0;
    end else if (dec_ready) begin
      dec_valid_reg <= bus.dec_valid_i;
      if (bus.dec_valid_i) begin
        dec_idx_reg  <= dec_idx_next;
        dec_hit_reg  <= dec_hit_next;
        dec_rule_reg <= match_rule;
      end
    end
  end

  assign bus.dec_ready_o = dec_ready;
  assign bus.dec_valid_o = dec_valid_reg;
  assign bus.dec_idx_o   = dec_idx_reg;
  assign bus.dec_hit_o   = dec_hit_reg;
  assign bus.dec_rule_o  = dec_rule_reg;

`ifdef ADDR_MAP_MISS_LOG_EN
  logic [31:0]          miss_cnt_reg;
  logic [AddrWidth-1:0] miss_addr_reg;
  logic                 miss_vld_reg;
  logic                 log_clr;

  // Clearing is allowed even when locked so software can always drain the log
  assign log_clr = cfg_wr && sel_ctrl && field == LOG_FLAG_FIELD;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_reg  <= '0;
      miss_addr_reg <= '0;
      miss_vld_reg  <= 1'b0;
    end else if (log_clr) begin
      miss_cnt_reg <= '0;
      miss_vld_reg <= 1'b0;
    end else if (dec_accept && !match_hit) begin
      if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      if (!miss_vld_reg) begin
        miss_addr_reg <= bus.dec_addr_i;
        miss_vld_reg  <= 1'b1;
      end
    end
  end
`endif

  logic [63:0] rdata_next;
  logic [63:0] cfg_rdata_reg;
  logic        cfg_rvalid_reg;

  always_comb begin
    rdata_next = '0;
    if (sel_rule) begin
      case (cfg_field_e'(field))
        FIELD_START: rdata_next = 64'(rule_start[rule_sel]);
        FIELD_END:   rdata_next = 64'(rule_end[rule_sel]);
        FIELD_IDX:   rdata_next = 64'(rule_idx[rule_sel]);
        default:     rdata_next = 64'(rule_en[rule_sel]);
      endcase
    end else if (sel_ctrl) begin
      case (field)
        CTRL_FIELD:     rdata_next = {62'd0, default_en_reg, lock_reg};
`ifdef ADDR_MAP_MISS_LOG_EN
        LOG_ADDR_FIELD: rdata_next = 64'(miss_addr_reg);
        LOG_CNT_FIELD:  rdata_next = 64'(miss_cnt_reg);
        LOG_FLAG_FIELD: rdata_next = 64'(miss_vld_reg);
`endif
        default:        rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_reg <= 1'b0;
      cfg_rdata_reg  <= '0;
    end else begin
      cfg_rvalid_reg <= bus.cfg_req_i;
      cfg_rdata_reg  <= (bus.cfg_req_i && !bus.cfg_we_i) ? rdata_next : '0;
    end
  end

  assign bus.cfg_rvalid_o = cfg_rvalid_reg;
  assign bus.cfg_rdata_o  = cfg_rdata_reg;

endmodule
